// File: rtl/led_pwm_multi_if.sv
// Configuration write bus for led_pwm_multi: one-cycle write strobe plus the
// invalid-channel error pulse returned by the LED block.
interface led_pwm_multi_if #(
    parameter int CH_W  = 4,
    parameter int PER_W = 16
);
    // wren_i is a single-cycle strobe with no back-pressure: every strobe is
    // consumed on the edge that samples it, and wr_err_o answers one cycle later.
    logic             wren_i;
    logic [CH_W-1:0]  ch_i;
    logic [1:0]       mode_i;
    logic [PER_W-1:0] per_i;
    logic [PER_W-1:0] duty_i;
    logic             wr_err_o;

    modport master (output wren_i, ch_i, mode_i, per_i, duty_i, input wr_err_o);
    modport slave  (input wren_i, ch_i, mode_i, per_i, duty_i, output wr_err_o);
endinterface

// File: rtl/led_pwm_multi.sv
// Multi-channel LED driver: shared tick prescaler, per-channel period counter,
// and glitch-free shadowed OFF/ON/BLINK/PWM configuration.
module led_pwm_multi #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 100000,
    parameter int PER_W    = 16,
    parameter int CH_W     = 4
) (
    input  logic              clk100,
    input  logic              rst,
    led_pwm_multi_if.slave    cfg,
    output logic [NUM_CH-1:0] led_o,
    output logic [NUM_CH-1:0] pending_o
);
    localparam int               PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [PER_W-1:0] P_ONE   = PER_W'(1);
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    logic [PS_W-1:0]  presc_q;
    logic             tick;
    logic [1:0]       mode_q    [NUM_CH];
    logic [PER_W-1:0] per_q     [NUM_CH];
    logic [PER_W-1:0] duty_q    [NUM_CH];
    logic [PER_W-1:0] cnt_q     [NUM_CH];
    logic [1:0]       sh_mode_q [NUM_CH];
    logic [PER_W-1:0] sh_per_q  [NUM_CH];
    logic [PER_W-1:0] sh_duty_q [NUM_CH];
    logic [NUM_CH-1:0] pend_q, led_q, led_d, hit, bnd;
    logic              err_q, wr_valid;
    logic [PER_W-1:0]  wr_per;

    assign tick     = (presc_q == PS_LAST);
    assign wr_valid = cfg.wren_i && (int'(cfg.ch_i) < NUM_CH);
    assign wr_per   = (cfg.per_i == '0) ? P_ONE : cfg.per_i;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst)       presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + PS_ONE;
    end

    always_comb begin
        hit = '0;
        bnd = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c] = wr_valid && (cfg.ch_i == CH_W'(c));
            bnd[c] = tick && (cnt_q[c] == per_q[c] - P_ONE);
        end
    end

    // BLINK threshold is computed one bit wider so per = 2^PER_W-1 cannot wrap.
    always_comb begin
        led_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (mode_q[c])
                MODE_ON:    led_d[c] = 1'b1;
                MODE_BLINK: led_d[c] = {1'b0, cnt_q[c]} < (({1'b0, per_q[c]} + {1'b0, P_ONE}) >> 1);
                MODE_PWM:   led_d[c] = cnt_q[c] < duty_q[c];
                default:    led_d[c] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            led_q  <= '0;
            err_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c]    <= MODE_OFF;
                per_q[c]     <= P_ONE;
                duty_q[c]    <= '0;
                cnt_q[c]     <= '0;
                sh_mode_q[c] <= MODE_OFF;
                sh_per_q[c]  <= P_ONE;
                sh_duty_q[c] <= '0;
            end
        end else begin
            err_q <= cfg.wren_i && !wr_valid;
            led_q <= led_d;
            for (int c = 0; c < NUM_CH; c++) begin
                // Static modes and boundary-coincident writes take effect at once.
                if (hit[c] && (!mode_q[c][1] || bnd[c])) begin
                    mode_q[c]    <= cfg.mode_i;
                    per_q[c]     <= wr_per;
                    duty_q[c]    <= cfg.duty_i;
                    sh_mode_q[c] <= cfg.mode_i;
                    sh_per_q[c]  <= wr_per;
                    sh_duty_q[c] <= cfg.duty_i;
                    cnt_q[c]     <= '0;
                    pend_q[c]    <= 1'b0;
                end else if (hit[c]) begin
                    sh_mode_q[c] <= cfg.mode_i;
                    sh_per_q[c]  <= wr_per;
                    sh_duty_q[c] <= cfg.duty_i;
                    pend_q[c]    <= 1'b1;
                    if (tick) cnt_q[c] <= cnt_q[c] + P_ONE;
                end else if (bnd[c]) begin
                    cnt_q[c]  <= '0;
                    pend_q[c] <= 1'b0;
                    if (pend_q[c]) begin
                        mode_q[c] <= sh_mode_q[c];
                        per_q[c]  <= sh_per_q[c];
                        duty_q[c] <= sh_duty_q[c];
                    end
                end else if (tick) begin
                    cnt_q[c] <= cnt_q[c] + P_ONE;
                end
            end
        end
    end

    assign led_o        = led_q;
    assign pending_o    = pend_q;
    assign cfg.wr_err_o = err_q;
endmodule

// File: tb/tb_led_pwm_multi.sv
// Self-checking bench for led_pwm_multi: directed scenarios plus random writes,
// compared every cycle against a tick-level behavioural model.
module tb_led_pwm_multi;
    localparam int NUM_CH   = 4;
    localparam int TICK_DIV = 4;
    localparam int PER_W    = 8;
    localparam int CH_W     = 4;

    logic              clk100 = 1'b0;
    logic              rst    = 1'b0;
    logic [NUM_CH-1:0] led_o;
    logic [NUM_CH-1:0] pending_o;

    led_pwm_multi_if #(.CH_W(CH_W), .PER_W(PER_W)) cfg ();

    led_pwm_multi #(
        .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .PER_W(PER_W), .CH_W(CH_W)
    ) dut (
        .clk100   (clk100),
        .rst      (rst),
        .cfg      (cfg),
        .led_o    (led_o),
        .pending_o(pending_o)
    );

    always #5 clk100 = ~clk100;

    // Reference model state: active/shadow config and tick position per channel.
    int m_mode [NUM_CH];
    int m_per  [NUM_CH];
    int m_duty [NUM_CH];
    int m_cnt  [NUM_CH];
    int s_mode [NUM_CH];
    int s_per  [NUM_CH];
    int s_duty [NUM_CH];
    bit m_pend [NUM_CH];
    int edge_n;
    bit exp_err;
    logic [NUM_CH-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit led_fn(input int mode, input int per, input int duty, input int cnt);
        case (mode)
            1:       return 1'b1;
            2:       return cnt < (per + 1) / 2;
            3:       return cnt < duty;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_per[c] = 1; m_duty[c] = 0; m_cnt[c] = 0;
            s_mode[c] = 0; s_per[c] = 1; s_duty[c] = 0; m_pend[c] = 0;
        end
        edge_n  = 0;
        exp_err = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit wr, input int ch, input int mode, input int per, input int duty);
        logic [NUM_CH-1:0] f;
        bit tick, hit, bnd;
        int np;
        for (int c = 0; c < NUM_CH; c++) f[c] = led_fn(m_mode[c], m_per[c], m_duty[c], m_cnt[c]);
        exp_q.push_back(f);
        exp_err = wr && (ch >= NUM_CH);
        edge_n++;
        tick = (edge_n % TICK_DIV) == 0;
        np   = (per == 0) ? 1 : per;
        for (int c = 0; c < NUM_CH; c++) begin
            hit = wr && (ch == c);
            bnd = tick && (m_cnt[c] == m_per[c] - 1);
            if (hit && (m_mode[c] < 2 || bnd)) begin
                m_mode[c] = mode; m_per[c] = np; m_duty[c] = duty;
                s_mode[c] = mode; s_per[c] = np; s_duty[c] = duty;
                m_cnt[c] = 0; m_pend[c] = 0;
            end else begin
                if (hit) begin
                    s_mode[c] = mode; s_per[c] = np; s_duty[c] = duty;
                    m_pend[c] = 1;
                end
                if (bnd) begin
                    if (m_pend[c]) begin
                        m_mode[c] = s_mode[c]; m_per[c] = s_per[c]; m_duty[c] = s_duty[c];
                    end
                    m_cnt[c] = 0; m_pend[c] = 0;
                end else if (tick) begin
                    m_cnt[c]++;
                end
            end
        end
    endtask

    task automatic step(input bit wr, input int ch, input int mode, input int per, input int duty);
        logic [NUM_CH-1:0] exp_led, exp_pend;
        cfg.wren_i = wr;
        cfg.ch_i   = CH_W'(ch);
        cfg.mode_i = 2'(mode);
        cfg.per_i  = PER_W'(per);
        cfg.duty_i = PER_W'(duty);
        @(posedge clk100);
        model_edge(wr, ch, mode, per, duty);
        #1;
        exp_led = exp_q.pop_front();
        for (int c = 0; c < NUM_CH; c++) exp_pend[c] = m_pend[c];
        check("led", 32'(led_o), 32'(exp_led));
        check("pending", 32'(pending_o), 32'(exp_pend));
        check("wr_err", 32'(cfg.wr_err_o), 32'(exp_err));
        cfg.wren_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_cnt(input int c, input int v);
        for (int i = 0; i < 400; i++) begin
            if (m_cnt[c] == v) return;
            step(0, 0, 0, 0, 0);
        end
        check("timeout_cnt", 32'd1, 32'd0);
    endtask

    task automatic wait_boundary(input int c);
        for (int i = 0; i < 400; i++) begin
            if (((edge_n + 1) % TICK_DIV) == 0 && m_cnt[c] == m_per[c] - 1) return;
            step(0, 0, 0, 0, 0);
        end
        check("timeout_bnd", 32'd1, 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_led", 32'(led_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_wr_err", 32'(cfg.wr_err_o), 32'd0);
        model_reset();
        @(posedge clk100);
        #1;
        rst = 1'b0;
    endtask

    int hi;

    initial begin
        cfg.wren_i = 1'b0; cfg.ch_i = '0; cfg.mode_i = '0; cfg.per_i = '0; cfg.duty_i = '0;
        #2;
        apply_reset();

        // Static ON then a mid-run reset with state present.
        step(1, 3, 1, 3, 0);
        step(1, 2, 3, 5, 2);
        step(1, 2, 3, 7, 4);
        idle(13);
        check("pre_rst_led3", 32'(led_o[3]), 32'd1);
        apply_reset();

        // BLINK per=6 from OFF: 3 ticks high, 3 low.
        step(1, 0, 2, 6, 0);
        idle(2);
        hi = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, 0, 0);
            hi += int'(led_o[0]);
        end
        check("blink6_high_cycles", 32'(hi), 32'd12);

        // PWM duty change mid-period is shadowed until the wrap.
        step(1, 1, 3, 10, 3);
        wait_cnt(1, 4);
        step(1, 1, 3, 10, 7);
        check("pwm_pend_set", 32'(pending_o[1]), 32'd1);
        for (int i = 0; i < 100 && pending_o[1]; i++) step(0, 0, 0, 0, 0);
        check("pwm_pend_clr", 32'(pending_o[1]), 32'd0);
        idle(44);

        // Write exactly on the boundary, then back-to-back writes mid-period.
        wait_boundary(1);
        step(1, 1, 3, 10, 2);
        check("bnd_pend", 32'(pending_o[1]), 32'd0);
        wait_cnt(1, 3);
        step(1, 1, 3, 10, 5);
        step(1, 1, 3, 10, 8);
        idle(90);

        // Edge values.
        step(1, 2, 2, 0, 0);
        idle(20);
        step(1, 3, 3, 10, 0);
        idle(50);
        step(1, 3, 3, 10, 255);
        idle(50);
        step(1, 2, 2, 255, 0);
        for (int i = 0; i < 100 && pending_o[2]; i++) step(0, 0, 0, 0, 0);
        idle(1);
        hi = 0;
        for (int i = 0; i < 255 * TICK_DIV; i++) begin
            step(0, 0, 0, 0, 0);
            hi += int'(led_o[2]);
        end
        check("blink255_high_cycles", 32'(hi), 32'd512);

        // Invalid channel.
        step(1, 5, 1, 3, 3);
        check("inv_err_pulse", 32'(cfg.wr_err_o), 32'd1);
        idle(1);
        check("inv_err_end", 32'(cfg.wr_err_o), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)
                step(1, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 14));
            else
                step(0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
